// File: rtl/fft2d_feed_ctrl_pkg.sv
// Shared constants and types for the fft_2d input sequencer and its beat counter.
package fft2d_feed_ctrl_pkg;

  localparam int unsigned NB     = 12;
  localparam int unsigned ROWS   = 32;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned COL_W  = $clog2(BEATS);
  localparam int unsigned ADDR_W = 1 + ROW_W + COL_W;

  typedef logic [NB-1:0] sfp_t;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StWaitRdy
  } feed_state_e;

endpackage

// File: rtl/fft2d_beat_cnt.sv
// Beat counter split into row/column fields. Load presets to 1 because beat 0 is
// issued on the same edge as the load.
module fft2d_beat_cnt #(
  parameter int unsigned RowW = 5,
  parameter int unsigned ColW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            en_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            wrap_o
);

  localparam int unsigned CntW = RowW + ColW;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CntW'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign {row_o, col_o} = cnt_q;
  assign wrap_o         = (cnt_q == '0);

endmodule

// File: rtl/fft2d_feed_ctrl.sv
// Reads one 32x32 complex frame from the four-bank buffer and streams it into fft_2d,
// ping-ponging buffers and queueing one pending request.
module fft2d_feed_ctrl
  import fft2d_feed_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frame_start_i,
  input  logic                    rdy_i,
  output logic                    mem_en_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic [LANES*2*NB-1:0]   mem_rdata_i,
  output logic                    start_o,
  output logic [LANES*NB-1:0]     dr_o,
  output logic [LANES*NB-1:0]     di_o,
  output logic                    valid_o,
  output logic                    buf_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o
);

  feed_state_e       state_q, state_d;
  logic              buf_q, buf_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              start_q, start_d;
  logic              en_q, en_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic             cnt_load, cnt_en, cnt_wrap;
  logic [ROW_W-1:0] cnt_row;
  logic [COL_W-1:0] cnt_col;
  logic             idle, start_now;

  fft2d_beat_cnt #(
    .RowW (ROW_W),
    .ColW (COL_W)
  ) u_beat_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .row_o  (cnt_row),
    .col_o  (cnt_col),
    .wrap_o (cnt_wrap)
  );

  assign idle      = (state_q == StIdle);
  assign start_now = idle && (frame_start_i || pend_q);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    addr_d   = addr_q;
    start_d  = 1'b0;
    en_d     = 1'b0;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    valid_d  = en_q;

    unique case (state_q)
      StIdle: begin
        if (start_now) begin
          state_d  = StFeed;
          start_d  = 1'b1;
          en_d     = 1'b1;
          addr_d   = {buf_q, {(ROW_W + COL_W){1'b0}}};
          cnt_load = 1'b1;
        end
      end
      StFeed: begin
        // Counter wraps to 0 only after address 255 has been issued.
        if (cnt_wrap) begin
          state_d = StWaitRdy;
        end else begin
          en_d   = 1'b1;
          addr_d = {buf_q, cnt_row, cnt_col};
          cnt_en = 1'b1;
        end
      end
      StWaitRdy: begin
        if (rdy_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
          buf_d   = ~buf_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_now && pend_q) begin
      pend_d = 1'b0;
    end
    // A request while a frame is already queued and cannot be consumed now is lost.
    if (frame_start_i) begin
      if (!idle && pend_q) begin
        ovf_d = 1'b1;
      end else if (!idle || pend_q) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      buf_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      start_q <= start_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
    end
  end

  // Lane 3 carries bank 0 so the MSB lane holds the lowest column.
  always_comb begin
    dr_o = '0;
    di_o = '0;
    if (valid_q) begin
      for (int l = 0; l < LANES; l++) begin
        dr_o[l*NB +: NB] = mem_rdata_i[(LANES-1-l)*2*NB + NB +: NB];
        di_o[l*NB +: NB] = mem_rdata_i[(LANES-1-l)*2*NB +: NB];
      end
    end
  end

  assign mem_en_o   = en_q;
  assign mem_addr_o = addr_q;
  assign start_o    = start_q;
  assign valid_o    = valid_q;
  assign buf_o      = buf_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fft2d_feed_ctrl.sv
// Directed bench for fft2d_feed_ctrl: behavioural 4-bank memory, beat capture monitor,
// table-driven beat checks and hand-written multi-cycle corner sequences.
module tb_fft2d_feed_ctrl;

  localparam int NB = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fs  = 1'b0;
  logic          rdy = 1'b0;
  logic          mem_en;
  logic [8:0]    mem_addr;
  logic [95:0]   rdata = '0;
  logic          start_o, valid_o, buf_o, busy_o, done_o, ovf_o;
  logic [47:0]   dr_o, di_o;

  fft2d_feed_ctrl u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_start_i (fs),
    .rdy_i         (rdy),
    .mem_en_o      (mem_en),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (rdata),
    .start_o       (start_o),
    .dr_o          (dr_o),
    .di_o          (di_o),
    .valid_o       (valid_o),
    .buf_o         (buf_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank b word at {buf,r,c}: re = 8b+c, im = {buf,r}.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        rdata[b*24 +: 24] <= {12'(8*b + int'(mem_addr[2:0])), 12'({mem_addr[8], mem_addr[7:3]})};
      end
    end
  end

  int          nstart, ndone, addr_bad;
  int          start_cyc [4];
  int          done_cyc  [4];
  int          nbeat     [4];
  int          nen       [4];
  int          first_addr[4];
  int          first_vcyc[4];
  int          last_vcyc [4];
  logic [47:0] cap_dr [4][256];
  logic [47:0] cap_di [4][256];

  always @(negedge clk) begin
    if (rst) begin
      nstart = 0;
      ndone = 0;
      addr_bad = 0;
      for (int f = 0; f < 4; f++) begin
        nbeat[f] = 0;
        nen[f] = 0;
      end
    end else begin
      if (start_o) begin
        if (nstart < 4) start_cyc[nstart] = cyc;
        nstart++;
      end
      if (done_o) begin
        if (ndone < 4) done_cyc[ndone] = cyc;
        ndone++;
      end
      if (nstart > 0 && nstart <= 4) begin
        if (mem_en) begin
          if (nen[nstart-1] == 0) first_addr[nstart-1] = int'(mem_addr);
          else if (int'(mem_addr) != first_addr[nstart-1] + nen[nstart-1]) addr_bad++;
          nen[nstart-1]++;
        end
        if (valid_o) begin
          if (nbeat[nstart-1] == 0) first_vcyc[nstart-1] = cyc;
          if (nbeat[nstart-1] < 256) begin
            cap_dr[nstart-1][nbeat[nstart-1]] = dr_o;
            cap_di[nstart-1][nbeat[nstart-1]] = di_o;
          end
          last_vcyc[nstart-1] = cyc;
          nbeat[nstart-1]++;
        end
      end
    end
  end

  typedef struct {
    int          beat;
    logic [47:0] dr;
    logic [47:0] di;
  } vec_t;

  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fs  = 1'b0;
    rdy = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    step(1);
    fs = 1'b0;
  endtask

  task automatic wait_beats(input int f, input int n, input int budget);
    int k = 0;
    while (nbeat[f] < n && k < budget) begin
      step(1);
      k++;
    end
    if (nbeat[f] < n) timeout_fail("wait_beats");
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (ndone < n && k < budget) begin
      step(1);
      k++;
    end
    if (ndone < n) timeout_fail("wait_done");
  endtask

  task automatic check_frame(input int f, input int exp_first, input bit b);
    logic [47:0] exp_di;
    chk("en_cycles", nen[f], 256);
    chk("first_addr", first_addr[f], exp_first);
    chk("addr_seq_bad", addr_bad, 0);
    chk("beat_count", nbeat[f], 256);
    chk("first_beat_after_start", first_vcyc[f] - start_cyc[f], 1);
    chk("beats_contiguous", last_vcyc[f] - first_vcyc[f], 255);
    for (int i = 0; i < 5; i++) begin
      exp_di = tbl[i].di + (b ? {4{12'd32}} : 48'd0);
      chk($sformatf("beat%0d_dr", tbl[i].beat), cap_dr[f][tbl[i].beat], tbl[i].dr);
      chk($sformatf("beat%0d_di", tbl[i].beat), cap_di[f][tbl[i].beat], exp_di);
    end
  endtask

  initial begin
    int t0;
    tbl[0] = '{beat: 0,   dr: {12'd0, 12'd8,  12'd16, 12'd24}, di: {4{12'd0}}};
    tbl[1] = '{beat: 9,   dr: {12'd1, 12'd9,  12'd17, 12'd25}, di: {4{12'd1}}};
    tbl[2] = '{beat: 77,  dr: {12'd5, 12'd13, 12'd21, 12'd29}, di: {4{12'd9}}};
    tbl[3] = '{beat: 100, dr: {12'd4, 12'd12, 12'd20, 12'd28}, di: {4{12'd12}}};
    tbl[4] = '{beat: 255, dr: {12'd7, 12'd15, 12'd23, 12'd31}, di: {4{12'd31}}};

    // Single frame from buffer 0.
    do_reset();
    chk("reset_ctrl", {start_o, mem_en, mem_addr, valid_o, buf_o, busy_o, done_o, ovf_o}, 0);
    chk("reset_data", {dr_o, di_o}, 0);
    pulse_fs();
    chk("start_first", {start_o, mem_en, mem_addr, busy_o}, {1'b1, 1'b1, 9'h000, 1'b1});
    step(1);
    chk("start_one_cycle", start_o, 0);
    wait_beats(0, 256, 400);
    step(1);
    chk("wait_rdy_state", {busy_o, mem_en, valid_o}, {1'b1, 1'b0, 1'b0});
    chk("data_gated", {dr_o, di_o}, 0);
    step(38);
    chk("no_done_without_rdy", ndone, 0);
    rdy = 1'b1;
    step(1);
    rdy = 1'b0;
    chk("done_after_rdy", {done_o, buf_o, busy_o}, {1'b1, 1'b1, 1'b0});
    step(1);
    chk("done_one_cycle", done_o, 0);
    chk("single_start", nstart, 1);
    check_frame(0, 'h000, 1'b0);

    // Pending request at beat 100; second frame reads buffer 1.
    do_reset();
    pulse_fs();
    wait_beats(0, 100, 300);
    pulse_fs();
    wait_beats(0, 256, 400);
    step(3);
    chk("pend_no_early_start", nstart, 1);
    rdy = 1'b1;
    wait_done(2, 700);
    rdy = 1'b0;
    chk("pend_two_starts", nstart, 2);
    chk("pend_start_after_done", start_cyc[1] - done_cyc[0], 1);
    chk("pend_no_overflow", ovf_o, 0);
    check_frame(1, 'h100, 1'b1);

    // Overflow: third request while one is pending is dropped.
    do_reset();
    pulse_fs();
    wait_beats(0, 50, 200);
    pulse_fs();
    chk("ovf_after_pend", ovf_o, 0);
    wait_beats(0, 60, 100);
    pulse_fs();
    chk("ovf_set", ovf_o, 1);
    rdy = 1'b1;
    wait_done(2, 800);
    step(300);
    rdy = 1'b0;
    chk("ovf_two_frames_only", {nstart[7:0], ndone[7:0]}, {8'd2, 8'd2});
    chk("ovf_sticky", ovf_o, 1);

    // rdy held high through FEED: done only after WAIT_RDY is entered.
    do_reset();
    rdy = 1'b1;
    t0 = cyc;
    pulse_fs();
    wait_done(1, 400);
    rdy = 1'b0;
    chk("rdy_early_done_vs_start", done_cyc[0] - start_cyc[0], 257);
    chk("rdy_early_done_vs_req", done_cyc[0] - t0, 258);
    step(2);

    // frame_start on the same cycle as the done transition.
    do_reset();
    pulse_fs();
    wait_beats(0, 256, 400);
    step(2);
    rdy = 1'b1;
    fs  = 1'b1;
    step(1);
    rdy = 1'b0;
    fs  = 1'b0;
    chk("same_cycle_done", {done_o, nstart[7:0]}, {1'b1, 8'd1});
    step(1);
    chk("same_cycle_restart", {start_o, mem_addr, ovf_o}, {1'b1, 9'h100, 1'b0});
    rdy = 1'b1;
    wait_done(2, 400);
    rdy = 1'b0;
    check_frame(1, 'h100, 1'b1);

    // Asynchronous reset mid-frame, then a clean restart from buffer 0.
    do_reset();
    pulse_fs();
    wait_beats(0, 77, 200);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_ctrl", {start_o, mem_en, mem_addr, valid_o, buf_o, busy_o, done_o, ovf_o}, 0);
    chk("async_reset_data", {dr_o, di_o}, 0);
    step(2);
    rst = 1'b0;
    step(1);
    pulse_fs();
    chk("restart_addr", {start_o, mem_addr, buf_o}, {1'b1, 9'h000, 1'b0});
    wait_beats(0, 256, 400);
    check_frame(0, 'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
